traffic_light_controller_nway: RTL and testbench

Parametrised successor of the 4-road fixed-cycle intersection controller. It serves NUM_ROADS approaches round-robin, and each road has a programmable green and yellow time. New behaviour over the previous generation:
- an all-red clearance interval between phases;
- vehicle-sensor skipping of empty roads;
- emergency pre-emption that passes through yellow and clearance, with one-hot request validation;
- a blinking all-yellow off mode.
The block sits at top level and drives the lamp outputs directly.

---
 rtl/traffic_light_controller_nway.sv | 262 ++++++++++++++++++++++++++
 tb/tb_traffic_light_controller_nway.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller_nway.sv
// N-approach round-robin intersection controller: programmable green/yellow, all-red clearance,
// sensor skipping, one-hot emergency pre-emption and a blinking all-yellow off mode.
module traffic_light_controller_nway #(
  parameter int unsigned NUM_ROADS      = 4,
  parameter int unsigned ROAD_W         = $clog2(NUM_ROADS),
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned FREQUENCY      = 2,
  parameter int unsigned GREEN_DEFAULT  = 24,
  parameter int unsigned YELLOW_DEFAULT = 4,
  parameter int unsigned CLEAR_DELAY    = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vsw,
  input  logic                   auto_mode,
  input  logic                   sensor_en,
  input  logic [NUM_ROADS-1:0]   veh_detect,
  input  logic [NUM_ROADS-1:0]   emergency_green,
  input  logic                   cfg_we,
  input  logic [ROAD_W-1:0]      cfg_road,
  input  logic [CNT_W-1:0]       cfg_green,
  input  logic [CNT_W-1:0]       cfg_yellow,
  output logic [3*NUM_ROADS-1:0] traffic_lights,
  output logic [ROAD_W-1:0]      active_road,
  output logic                   system_off,
  output logic                   emg_invalid,
  output logic                   fault
);

  localparam int unsigned PRE_W = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;
  localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_DEFAULT);
  localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_DEFAULT);
  localparam logic [CNT_W-1:0] CLEAR_C  = CNT_W'(CLEAR_DELAY);

  typedef enum logic [2:0] {
    StInitRed,
    StGreen,
    StYellow,
    StClear,
    StFlash
  } state_e;

  function automatic logic [CNT_W-1:0] fix_dur(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  state_e             r_state;
  logic [ROAD_W-1:0]  r_road;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_cur_dur;
  logic [PRE_W-1:0]   r_presc;
  logic               r_blink;
  logic               r_after_flash;
  logic [CNT_W-1:0]   r_cfg_green  [NUM_ROADS];
  logic [CNT_W-1:0]   r_cfg_yellow [NUM_ROADS];
  logic               r_system_off;
  logic               r_emg_invalid;
  logic               r_fault;

  logic               w_tick;
  logic               w_phase_end;
  logic               w_emg_onehot;
  logic [ROAD_W-1:0]  w_emg_tgt;
  logic [ROAD_W-1:0]  w_road_inc;
  logic               w_sensor_hit;
  logic [ROAD_W-1:0]  w_sensor_road;
  logic [ROAD_W-1:0]  w_next_road;
  state_e             w_state_nxt;
  logic [ROAD_W-1:0]  w_road_nxt;
  logic               w_change;
  logic               w_hold;
  logic [CNT_W-1:0]   w_dur_nxt;
  logic [3*NUM_ROADS-1:0] w_lights;
  logic               w_conflict;

  assign w_tick       = (r_presc == PRE_W'(FREQUENCY - 1));
  assign w_phase_end  = w_tick && (r_timer == r_cur_dur - CNT_W'(1));
  assign w_emg_onehot = (emergency_green != '0) &&
                        ((emergency_green & (emergency_green - NUM_ROADS'(1))) == '0);
  assign w_road_inc   = (r_road == ROAD_W'(NUM_ROADS - 1)) ? '0 : r_road + ROAD_W'(1);

  always_comb begin
    w_emg_tgt = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      if (emergency_green[i]) w_emg_tgt = ROAD_W'(i);
    end
  end

  // Descending scan so the nearest road after r_road (cyclically) wins.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    w_sensor_hit  = 1'b0;
    w_sensor_road = w_road_inc;
    for (int k = NUM_ROADS; k >= 1; k--) begin
      idx = (int'(r_road) + k) % NUM_ROADS;
      if (veh_detect[ROAD_W'(idx)]) begin
        w_sensor_hit  = 1'b1;
        w_sensor_road = ROAD_W'(idx);
      end
    end
  end

  always_comb begin
    w_next_road = w_road_inc;
    if (w_emg_onehot) begin
      w_next_road = w_emg_tgt;
    end else if (r_after_flash) begin
      w_next_road = '0;
    end else if (sensor_en && w_sensor_hit) begin
      w_next_road = w_sensor_road;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_road_nxt  = r_road;
    w_change    = 1'b0;
    w_hold      = 1'b0;
    if (!vsw) begin
      if (r_state != StFlash) begin
        w_state_nxt = StFlash;
        w_change    = 1'b1;
      end
    end else begin
      case (r_state)
        StInitRed: begin
          if (w_phase_end) begin
            w_state_nxt = StGreen;
            w_road_nxt  = '0;
            w_change    = 1'b1;
          end
        end
        StGreen: begin
          if (w_emg_onehot && (w_emg_tgt != r_road)) begin
            w_state_nxt = StYellow;
            w_change    = 1'b1;
          end else if (w_emg_onehot) begin
            w_hold = 1'b1;
          end else if (w_phase_end) begin
            w_state_nxt = StYellow;
            w_change    = 1'b1;
          end
        end
        StYellow: begin
          if (w_phase_end) begin
            w_state_nxt = StClear;
            w_change    = 1'b1;
          end
        end
        StClear: begin
          if (w_phase_end) begin
            w_state_nxt = StGreen;
            w_road_nxt  = w_next_road;
            w_change    = 1'b1;
          end
        end
        StFlash: begin
          w_state_nxt = StClear;
          w_road_nxt  = '0;
          w_change    = 1'b1;
        end
        default: begin
          w_state_nxt = StInitRed;
          w_road_nxt  = '0;
          w_change    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    case (w_state_nxt)
      StGreen:  w_dur_nxt = fix_dur(auto_mode ? GREEN_C : r_cfg_green[w_road_nxt]);
      StYellow: w_dur_nxt = fix_dur(auto_mode ? YELLOW_C : r_cfg_yellow[w_road_nxt]);
      default:  w_dur_nxt = fix_dur(CLEAR_C);
    endcase
  end

  always_comb begin
    w_lights = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      case (r_state)
        StGreen:  w_lights[3*i +: 3] = (r_road == ROAD_W'(i)) ? 3'b001 : 3'b100;
        StYellow: w_lights[3*i +: 3] = (r_road == ROAD_W'(i)) ? 3'b010 : 3'b100;
        StFlash:  w_lights[3*i +: 3] = {1'b0, r_blink, 1'b0};
        default:  w_lights[3*i +: 3] = 3'b100;
      endcase
    end
  end

  always_comb begin
    int unsigned n_open;
    logic [2:0]  g;
    n_open     = 0;
    g          = '0;
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      g = w_lights[3*i +: 3];
      if ((g[0] & g[1]) | (g[0] & g[2]) | (g[1] & g[2])) w_conflict = 1'b1;
      if (!g[2]) n_open = n_open + 1;
    end
    if ((r_state != StFlash) && (n_open > 1)) w_conflict = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StInitRed;
      r_road        <= '0;
      r_timer       <= '0;
      r_cur_dur     <= fix_dur(CLEAR_C);
      r_presc       <= '0;
      r_blink       <= 1'b0;
      r_after_flash <= 1'b0;
      r_system_off  <= 1'b0;
      r_emg_invalid <= 1'b0;
      r_fault       <= 1'b0;
      for (int i = 0; i < NUM_ROADS; i++) begin
        r_cfg_green[i]  <= GREEN_C;
        r_cfg_yellow[i] <= YELLOW_C;
      end
    end else begin
      r_system_off  <= ~vsw;
      r_emg_invalid <= (emergency_green != '0) && !w_emg_onehot;
      r_fault       <= w_conflict;
      if (cfg_we && (32'(cfg_road) < NUM_ROADS)) begin
        r_cfg_green[cfg_road]  <= cfg_green;
        r_cfg_yellow[cfg_road] <= cfg_yellow;
      end
      if (w_change) begin
        r_state   <= w_state_nxt;
        r_road    <= w_road_nxt;
        r_presc   <= '0;
        r_timer   <= '0;
        r_cur_dur <= w_dur_nxt;
        // Flash always starts dark so the blink phase is independent of history.
        if (w_state_nxt == StFlash) r_blink <= 1'b0;
        if (r_state == StFlash) begin
          r_after_flash <= 1'b1;
        end else if (w_state_nxt == StGreen) begin
          r_after_flash <= 1'b0;
        end
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
        if (w_tick) begin
          if (r_state == StFlash) begin
            r_blink <= ~r_blink;
          end else if (!w_hold) begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
      end
    end
  end

  assign traffic_lights = w_lights;
  assign active_road    = r_road;
  assign system_off     = r_system_off;
  assign emg_invalid    = r_emg_invalid;
  assign fault          = r_fault;

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// Randomised bench for traffic_light_controller_nway against a seconds-countdown reference model.
module tb_traffic_light_controller_nway;
  localparam int N  = 4;
  localparam int RW = 2;
  localparam int CW = 8;
  localparam int F  = 2;
  localparam int GD = 24;
  localparam int YD = 4;
  localparam int CD = 1;

  localparam int PH_INIT = 0, PH_GREEN = 1, PH_YELLOW = 2, PH_CLEAR = 3, PH_FLASH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vsw = 1'b1;
  logic            auto_mode = 1'b1;
  logic            sensor_en = 1'b0;
  logic [N-1:0]    veh_detect = '0;
  logic [N-1:0]    emergency_green = '0;
  logic            cfg_we = 1'b0;
  logic [RW-1:0]   cfg_road = '0;
  logic [CW-1:0]   cfg_green = '0;
  logic [CW-1:0]   cfg_yellow = '0;
  logic [3*N-1:0]  traffic_lights;
  logic [RW-1:0]   active_road;
  logic            system_off;
  logic            emg_invalid;
  logic            fault;

  traffic_light_controller_nway dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .vsw             (vsw),
    .auto_mode       (auto_mode),
    .sensor_en       (sensor_en),
    .veh_detect      (veh_detect),
    .emergency_green (emergency_green),
    .cfg_we          (cfg_we),
    .cfg_road        (cfg_road),
    .cfg_green       (cfg_green),
    .cfg_yellow      (cfg_yellow),
    .traffic_lights  (traffic_lights),
    .active_road     (active_road),
    .system_off      (system_off),
    .emg_invalid     (emg_invalid),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase, road, seconds still owed, cycles since phase entry.
  int   m_ph, m_road, m_secs, m_cyc, m_blink, m_after_flash;
  int   m_cg [N];
  int   m_cy [N];
  logic m_sysoff, m_emginv;

  function automatic logic [3*N-1:0] lamps(int ph, int road, int blink);
    logic [3*N-1:0] l;
    l = '0;
    for (int i = 0; i < N; i++) begin
      if (ph == PH_FLASH)       l[3*i +: 3] = (blink != 0) ? 3'b010 : 3'b000;
      else if (ph == PH_GREEN)  l[3*i +: 3] = (i == road) ? 3'b001 : 3'b100;
      else if (ph == PH_YELLOW) l[3*i +: 3] = (i == road) ? 3'b010 : 3'b100;
      else                      l[3*i +: 3] = 3'b100;
    end
    return l;
  endfunction

  function automatic int dur(int ph, int road);
    int d;
    if (ph == PH_GREEN)       d = auto_mode ? GD : m_cg[road];
    else if (ph == PH_YELLOW) d = auto_mode ? YD : m_cy[road];
    else                      d = CD;
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int emg_target();
    if ($countones(emergency_green) != 1) return -1;
    for (int i = 0; i < N; i++) if (emergency_green[i]) return i;
    return -1;
  endfunction

  function automatic int pick();
    int t;
    t = emg_target();
    if (t >= 0) return t;
    if (m_after_flash != 0) return 0;
    if (sensor_en) begin
      for (int k = 1; k <= N; k++) if (veh_detect[(m_road + k) % N]) return (m_road + k) % N;
    end
    return (m_road + 1) % N;
  endfunction

  task automatic go(int ph, int road);
    m_secs = dur(ph, road);
    m_ph   = ph;
    m_road = road;
    m_cyc  = 0;
    if (ph == PH_GREEN) m_after_flash = 0;
    if (ph == PH_FLASH) m_blink = 0;
  endtask

  task automatic adv(bit tick, bit hold);
    m_cyc++;
    if (tick && !hold) m_secs--;
  endtask

  task automatic model_reset();
    m_ph = PH_INIT; m_road = 0; m_cyc = 0; m_secs = (CD == 0) ? 1 : CD;
    m_blink = 0; m_after_flash = 0; m_sysoff = 1'b0; m_emginv = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cg[i] = GD;
      m_cy[i] = YD;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit tick, ends;
    int t;
    tick = ((m_cyc % F) == F - 1);
    ends = tick && (m_secs == 1);
    t    = emg_target();
    if (!vsw) begin
      if (m_ph != PH_FLASH) go(PH_FLASH, m_road);
      else begin
        if (tick) m_blink ^= 1;
        m_cyc++;
      end
    end else begin
      case (m_ph)
        PH_INIT:   if (ends) go(PH_GREEN, 0); else adv(tick, 0);
        PH_GREEN: begin
          if (t >= 0 && t != m_road) go(PH_YELLOW, m_road);
          else if (t >= 0) adv(tick, 1);
          else if (ends) go(PH_YELLOW, m_road);
          else adv(tick, 0);
        end
        PH_YELLOW: if (ends) go(PH_CLEAR, m_road); else adv(tick, 0);
        PH_CLEAR:  if (ends) go(PH_GREEN, pick()); else adv(tick, 0);
        default: begin
          go(PH_CLEAR, 0);
          m_after_flash = 1;
        end
      endcase
    end
    if (cfg_we && int'(cfg_road) < N) begin
      m_cg[cfg_road] = int'(cfg_green);
      m_cy[cfg_road] = int'(cfg_yellow);
    end
    m_sysoff = !vsw;
    m_emginv = (emergency_green != '0) && ($countones(emergency_green) != 1);
  endtask

  task automatic check(string tag);
    logic [3*N-1:0] exp_l;
    exp_l = lamps(m_ph, m_road, m_blink);
    vectors++;
    assert (traffic_lights === exp_l) else begin
      miscompares++;
      $error("FAIL %s lamps: got %b expected %b", tag, traffic_lights, exp_l);
    end
    vectors++;
    assert (active_road === RW'(m_road)) else begin
      miscompares++;
      $error("FAIL %s active_road: got %0d expected %0d", tag, active_road, m_road);
    end
    vectors++;
    assert (system_off === m_sysoff) else begin
      miscompares++;
      $error("FAIL %s system_off: got %b expected %b", tag, system_off, m_sysoff);
    end
    vectors++;
    assert (emg_invalid === m_emginv) else begin
      miscompares++;
      $error("FAIL %s emg_invalid: got %b expected %b", tag, emg_invalid, m_emginv);
    end
    vectors++;
    assert (fault === 1'b0) else begin
      miscompares++;
      $error("FAIL %s fault: got %b expected 0", tag, fault);
    end
  endtask

  task automatic cycle(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic direct(string tag, logic [3*N-1:0] exp_l);
    vectors++;
    assert (traffic_lights === exp_l) else begin
      miscompares++;
      $error("FAIL %s: lamps got %b expected %b", tag, traffic_lights, exp_l);
    end
  endtask

  initial begin
    int emg_left;
    int vsw_left;
    int veh_left;
    bit found;

    model_reset();
    #1;
    check("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Auto fixed cycle: road1 green exactly 60 edges after release.
    for (int i = 1; i <= 240; i++) begin
      cycle("auto");
      if (i == 59) direct("auto_clear_before_r1", 12'b100_100_100_100);
      if (i == 60) direct("auto_r1_green", 12'b100_100_001_100);
    end

    // Programmed durations with random config writes.
    auto_mode = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_road   = RW'($urandom_range(0, N - 1));
      cfg_green  = CW'($urandom_range(0, 5));
      cfg_yellow = CW'($urandom_range(0, 3));
      cycle("manual");
    end
    cfg_we = 1'b0;

    // Sensor skipping, including empty-detector intervals.
    sensor_en = 1'b1;
    veh_left  = 0;
    for (int i = 0; i < 500; i++) begin
      if (veh_left == 0) begin
        veh_detect = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
        veh_left   = $urandom_range(1, 15);
      end
      veh_left--;
      cycle("sensor");
    end
    sensor_en  = 1'b0;
    veh_detect = '0;

    // Emergency pre-emption: valid one-hot, invalid multi-bit and idle.
    emg_left = 0;
    for (int i = 0; i < 700; i++) begin
      if (emg_left == 0) begin
        case ($urandom_range(0, 3))
          0:       emergency_green = '0;
          1, 2:    emergency_green = N'(1 << $urandom_range(0, N - 1));
          default: emergency_green = ($urandom_range(0, 1) == 0) ? 4'b0110 : 4'b1001;
        endcase
        emg_left = $urandom_range(1, 30);
      end
      emg_left--;
      cycle("emergency");
    end
    emergency_green = '0;

    // Flash off mode.
    vsw_left = 0;
    for (int i = 0; i < 300; i++) begin
      if (vsw_left == 0) begin
        vsw      = ~vsw;
        vsw_left = vsw ? $urandom_range(10, 40) : $urandom_range(3, 20);
      end
      vsw_left--;
      cycle("flash");
    end
    vsw = 1'b1;

    // Asynchronous reset mid-yellow, away from any clock edge.
    auto_mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle("to_yellow");
      found = (m_ph == PH_YELLOW);
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL yellow_wait: got timeout expected yellow phase");
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    direct("async_reset_all_red", 12'b100_100_100_100);
    check("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      cycle("post_reset");
      if (i == 2) direct("post_reset_r0_green", 12'b100_100_100_001);
    end

    // Everything randomised together with short programmed phases.
    auto_mode = 1'b0;
    emg_left  = 0;
    vsw_left  = 50;
    for (int i = 0; i < 900; i++) begin
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_road   = RW'($urandom_range(0, N - 1));
      cfg_green  = CW'($urandom_range(0, 4));
      cfg_yellow = CW'($urandom_range(0, 2));
      sensor_en  = ($urandom_range(0, 1) == 1);
      veh_detect = N'($urandom_range(0, 15));
      if (emg_left == 0) begin
        emergency_green = ($urandom_range(0, 2) == 0) ? N'(1 << $urandom_range(0, N - 1)) :
                          (($urandom_range(0, 4) == 0) ? 4'b1100 : '0);
        emg_left = $urandom_range(1, 20);
      end
      emg_left--;
      if (vsw_left == 0) begin
        vsw      = ~vsw;
        vsw_left = vsw ? $urandom_range(20, 80) : $urandom_range(2, 10);
      end
      vsw_left--;
      cycle("mixed");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
